// File: rtl/pwm_capture.sv
// pwm_capture: measures the high time and rising-to-rising period of an
// asynchronous PWM line in SysClk cycles.
// Each complete period is published with a one-cycle Valid strobe.
// A line with no rising edge for TIMEOUT cycles is reported once as stuck.
// Optional feature macro: PWM_CAPTURE_FILTER_EN inserts a 3-sample majority
// filter after the synchronizer. It rejects single-cycle glitches and adds
// two cycles of latency.
module pwm_capture #(
    parameter int TIMEOUT  = 1024,
    parameter int PERIOD_W = 16
) (
    input  logic                SysClk,
    input  logic                Reset,
    input  logic                PWM,
    output logic [7:0]          DutyCycle,
    output logic [PERIOD_W-1:0] Period,
    output logic                Valid,
    output logic                Stuck
);

    typedef enum logic [1:0] {
        SYNC  = 2'd0,
        MEAS  = 2'd1,
        STUCK = 2'd2
    } state_t;

    localparam logic [PERIOD_W-1:0] PERIOD_ONE = PERIOD_W'(1);
    localparam logic [PERIOD_W-1:0] PERIOD_MAX = '1;
    localparam logic [15:0]         IDLE_ONE   = 16'd1;
    localparam logic [15:0]         IDLE_LIMIT = 16'(TIMEOUT);

    logic                s1;
    logic                s2;
    logic                s3;
    logic                level;
    logic                rise;
    logic                timeout;
    state_t              state;
    state_t              state_nxt;
    logic                do_publish;
    logic                do_stuck;
    logic                do_reload;
    logic [PERIOD_W-1:0] period_cnt;
    logic [7:0]          high_cnt;
    logic [15:0]         idle_cnt;

    // Two-flop synchronizer that brings the asynchronous PWM pin into the SysClk domain.
    always_ff @(posedge SysClk or posedge Reset) begin
        if (Reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= PWM;
            s2 <= s1;
        end
    end

`ifdef PWM_CAPTURE_FILTER_EN
    logic m1;
    logic m2;
    logic filt;

    // Majority of three consecutive samples.
    // A lone one-cycle pulse never wins the vote.
    // Wider pulses pass with their width intact.
    always_ff @(posedge SysClk or posedge Reset) begin
        if (Reset) begin
            m1   <= 1'b0;
            m2   <= 1'b0;
            filt <= 1'b0;
        end else begin
            m1   <= s2;
            m2   <= m1;
            filt <= (s2 & m1) | (s2 & m2) | (m1 & m2);
        end
    end

    assign level = filt;
`else
    assign level = s2;
`endif

    // Delayed copy of the conditioned level, used for edge detection.
    always_ff @(posedge SysClk or posedge Reset) begin
        if (Reset) begin
            s3 <= 1'b0;
        end else begin
            s3 <= level;
        end
    end

    // A fall only matters through level gating high_cnt, so only the rise is decoded.
    assign rise    = level & ~s3;
    assign timeout = (idle_cnt == IDLE_LIMIT);

    // State register.
    always_ff @(posedge SysClk or posedge Reset) begin
        if (Reset) begin
            state <= SYNC;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and datapath strobes.
    // A rise always beats a simultaneous timeout.
    always_comb begin
        state_nxt  = state;
        do_publish = 1'b0;
        do_stuck   = 1'b0;
        do_reload  = 1'b0;
        case (state)
            SYNC: begin
                if (rise) begin
                    state_nxt = MEAS;
                    do_reload = 1'b1;
                end else if (timeout) begin
                    state_nxt = STUCK;
                    do_stuck  = 1'b1;
                end
            end
            MEAS: begin
                if (rise) begin
                    do_publish = 1'b1;
                    do_reload  = 1'b1;
                end else if (timeout) begin
                    state_nxt = STUCK;
                    do_stuck  = 1'b1;
                end
            end
            STUCK: begin
                if (rise) begin
                    state_nxt = MEAS;
                    do_reload = 1'b1;
                end
            end
            default: begin
                state_nxt = SYNC;
            end
        endcase
    end

    // Saturating measurement counters.
    // idle_cnt tracks cycles since the last rise, or since reset, for the stuck timeout.
    always_ff @(posedge SysClk or posedge Reset) begin
        if (Reset) begin
            period_cnt <= '0;
            high_cnt   <= '0;
            idle_cnt   <= '0;
        end else if (do_reload) begin
            period_cnt <= PERIOD_ONE;
            high_cnt   <= 8'd1;
            idle_cnt   <= IDLE_ONE;
        end else if (state == MEAS) begin
            if (period_cnt != PERIOD_MAX) begin
                period_cnt <= period_cnt + PERIOD_ONE;
            end
            if (level && (high_cnt != 8'hFF)) begin
                high_cnt <= high_cnt + 8'd1;
            end
            if (idle_cnt != IDLE_LIMIT) begin
                idle_cnt <= idle_cnt + IDLE_ONE;
            end
        end else if (state == SYNC) begin
            if (idle_cnt != IDLE_LIMIT) begin
                idle_cnt <= idle_cnt + IDLE_ONE;
            end
        end
    end

    // Registered outputs.
    // Data changes only together with the one-cycle Valid strobe.
    always_ff @(posedge SysClk or posedge Reset) begin
        if (Reset) begin
            DutyCycle <= '0;
            Period    <= '0;
            Valid     <= 1'b0;
            Stuck     <= 1'b0;
        end else begin
            Valid <= do_publish | do_stuck;
            if (do_publish) begin
                DutyCycle <= high_cnt;
                Period    <= period_cnt;
                Stuck     <= 1'b0;
            end else if (do_stuck) begin
                DutyCycle <= level ? 8'hFF : 8'h00;
                Period    <= '0;
                Stuck     <= 1'b1;
            end
        end
    end

endmodule

// File: doc/pwm_capture.md
# pwm_capture

PWM decoder for the LED subsystem: receives a PWM square wave, such as the output of the team's PWM LED generator or an external PWM source, and measures its high time and period in SysClk cycles. For each complete period it publishes the measured duty count and period with a one-cycle valid strobe. A timeout detects stuck-low (0 %) and stuck-high (100 %) lines. It sits on the loopback/feedback path so firmware and the bench can check the duty cycle that was actually emitted.

## Interface
- TIMEOUT, 1024, cycles without a rising edge before declaring the line stuck; legal range 2..65535
- PERIOD_W, 16, width of the period counter and the Period output
- SysClk  input  1  system clock; all logic is on the rising edge
- Reset  input  1  asynchronous, active-high reset
- PWM  input  1  PWM line; asynchronous to SysClk
- DutyCycle  output  8  measured high-time count, saturated to 255
- Period  output  PERIOD_W  measured rising-to-rising period in cycles, saturated to all-ones; 0 on a stuck report
- Valid  output  1  one-cycle strobe; DutyCycle, Period and Stuck are updated on this cycle
- Stuck  output  1  high while the line has had no rising edge for TIMEOUT cycles

## Operation
- Input conditioning:
  - PWM passes through a 2-flop synchronizer (s1, s2).
  - s3 is a delayed copy of s2.
  - rise = s2 & ~s3; fall = ~s2 & s3.
- States: SYNC (after reset, waiting for the first rise), MEAS (measuring), STUCK.
- SYNC:
  - HighCnt and PeriodCnt hold 0.
  - On rise: go to MEAS, set PeriodCnt=1, HighCnt=1, publish nothing, because the first period is partial.
- MEAS, each cycle with no rise:
  - PeriodCnt increments, saturating at all-ones.
  - HighCnt increments when s2=1, saturating at 255.
- MEAS, on rise:
  - Publish DutyCycle=HighCnt and Period=PeriodCnt (the values before this cycle's update).
  - Set Stuck=0 and pulse Valid.
  - Reload PeriodCnt=1 and HighCnt=1.
- Timeout, in SYNC or MEAS:
  - Trigger: PeriodCnt (or a separate idle counter in SYNC) reaches TIMEOUT with no rise.
  - Publish DutyCycle = s2 ? 255 : 0, Period=0, Stuck=1; pulse Valid once; go to STUCK.
- STUCK:
  - No further Valid pulses. Outputs hold.
  - On rise: go to MEAS with PeriodCnt=HighCnt=1, no publish. Stuck stays 1 until the next Valid from MEAS.
- A fall only affects HighCnt, through s2; it causes no publish.
- Rise and timeout in the same cycle: rise wins and the measurement is published.
- Reset mid-measurement: all counters clear, state goes to SYNC, and the partial period is discarded.

## Timing
- Reset values: DutyCycle=0, Period=0, Valid=0, Stuck=0. Internal: s1=s2=s3=0, state SYNC, counters 0.
- Latency: a PWM rise first sampled at clock edge k produces Valid high in the cycle following edge k+2.
- Valid is registered and lasts exactly 1 cycle. Output data is stable from that cycle until the next Valid.
- Minimum resolvable pulse: 1 cycle high or low after synchronization. Narrower pulses may be missed.
- Arithmetic:
  - Counters saturate and never wrap.
  - A period longer than 2^PERIOD_W-1 but shorter than TIMEOUT reports Period all-ones. This is unreachable with the defaults.
- The synchronized edge lags the pin by 2–3 cycles. Because both edges share that lag, Duty and Period are exact for a clean input.

## Configuration
- PWM_CAPTURE_FILTER_EN:
  - Defined: a 3-sample majority filter sits between s2 and the edge detector. A single-cycle glitch is rejected, and latency grows by 2 cycles (Valid after edge k+4). The minimum valid pulse becomes 2 cycles.
  - Undefined: no filter; behaviour is as above.

## Test plan
- Reset asserted mid-period, then released; PWM 64 high / 192 low repeated -> the first rise after release yields no Valid; each later rise gives DutyCycle=64, Period=256, Stuck=0, with Valid exactly 1 cycle wide.
- PWM 1 high / 255 low -> DutyCycle=1, Period=256. PWM 255 high / 1 low -> DutyCycle=255, Period=256. PWM 300 high / 100 low -> DutyCycle=255 (saturated), Period=400.
- PWM held low with TIMEOUT=1024 -> one Valid with DutyCycle=0, Period=0, Stuck=1, then no further Valid. Held high -> DutyCycle=255, Stuck=1.
- From STUCK, restart 128/128 PWM -> the first rise gives no Valid; the second rise gives DutyCycle=128, Period=256, Stuck=0.
- Check latency: drive a PWM rise just before edge k -> Valid high in the cycle after edge k+2 (k+4 with PWM_CAPTURE_FILTER_EN).
- With PWM_CAPTURE_FILTER_EN, inject a 1-cycle high glitch into the 64/192 low phase -> no extra Valid, still DutyCycle=64, Period=256. Without the macro -> a spurious short-period Valid.
